// File: rtl/cache_ctrl_pkg.sv
// Shared geometry, state encoding and address helpers for the direct-mapped
// write-back cache controller.
package cache_ctrl_pkg;

  localparam int ADDR_WIDTH   = 16;
  localparam int BLOCK_SIZE   = 16;
  localparam int CACHE_LINES  = 16;
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int INDEX_WIDTH  = $clog2(CACHE_LINES);
  localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int LINE_BITS    = BLOCK_SIZE * 8;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [LINE_BITS-1:0]   line_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_RF_REQ,
    S_RF_WAIT,
    S_RESP
  } state_e;

  function automatic index_t addr_index(input addr_t addr);
    return addr[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic tag_t addr_tag(input addr_t addr);
    return addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic addr_t block_addr(input tag_t tag, input index_t index);
    return {tag, index, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Per-line tag/valid/dirty/data storage with a combinational read port and a
// single write port; only valid and dirty are cleared by reset.
module cache_line_store
  import cache_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  index_t rd_index,
  output logic   rd_valid,
  output logic   rd_dirty,
  output tag_t   rd_tag,
  output line_t  rd_data,
  input  index_t wr_index,
  input  logic   wr_valid_en,
  input  logic   wr_dirty_en,
  input  logic   wr_tag_en,
  input  logic   wr_data_en,
  input  logic   wr_valid,
  input  logic   wr_dirty,
  input  tag_t   wr_tag,
  input  line_t  wr_data
);

  logic [CACHE_LINES-1:0] valid_q, valid_d;
  logic [CACHE_LINES-1:0] dirty_q, dirty_d;
  tag_t                   tag_q  [CACHE_LINES];
  line_t                  data_q [CACHE_LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_valid_en) valid_d[wr_index] = wr_valid;
    if (wr_dirty_en) dirty_d[wr_index] = wr_dirty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays are plain storage; their contents are only trusted
  // once the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_tag_en)  tag_q[wr_index]  <= wr_tag;
    if (wr_data_en) data_q[wr_index] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_access_controller.sv
// Request sequencer for the direct-mapped write-back cache: lookup, victim
// writeback, refill, response and access statistics.
module cache_access_controller
  import cache_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [LINE_BITS-1:0]  cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic                  cpu_resp_hit,
  output logic [LINE_BITS-1:0]  cpu_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_BITS-1:0]  mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [LINE_BITS-1:0]  mem_resp_rdata,
  output logic [31:0]           stat_requests,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_writebacks
);

  state_e      state_q, state_d;
  addr_t       req_addr_q, req_addr_d;
  logic        req_write_q, req_write_d;
  line_t       req_wdata_q, req_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_hit_q, resp_hit_d;
  line_t       resp_rdata_q, resp_rdata_d;
  logic        mreq_valid_q, mreq_valid_d;
  logic        mreq_write_q, mreq_write_d;
  addr_t       mreq_addr_q, mreq_addr_d;
  line_t       mreq_wdata_q, mreq_wdata_d;
  logic [31:0] st_req_q, st_req_d;
  logic [31:0] st_hit_q, st_hit_d;
  logic [31:0] st_miss_q, st_miss_d;
  logic [31:0] st_wb_q, st_wb_d;

  logic   rd_valid, rd_dirty;
  tag_t   rd_tag;
  line_t  rd_data;
  logic   wr_valid_en, wr_dirty_en, wr_tag_en, wr_data_en;
  logic   wr_valid, wr_dirty;
  line_t  wr_data;
  index_t req_index;
  tag_t   req_tag;
  logic   lookup_hit;
  line_t  fill_data;

  assign req_index  = addr_index(req_addr_q);
  assign req_tag    = addr_tag(req_addr_q);
  assign lookup_hit = rd_valid && (rd_tag == req_tag);
  assign fill_data  = req_write_q ? req_wdata_q : mem_resp_rdata;

  cache_line_store u_store (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_index    (req_index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_index    (req_index),
    .wr_valid_en (wr_valid_en),
    .wr_dirty_en (wr_dirty_en),
    .wr_tag_en   (wr_tag_en),
    .wr_data_en  (wr_data_en),
    .wr_valid    (wr_valid),
    .wr_dirty    (wr_dirty),
    .wr_tag      (req_tag),
    .wr_data     (wr_data)
  );

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_write_d  = req_write_q;
    req_wdata_d  = req_wdata_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_rdata_d = resp_rdata_q;
    mreq_valid_d = mreq_valid_q;
    mreq_write_d = mreq_write_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;
    st_req_d     = st_req_q;
    st_hit_d     = st_hit_q;
    st_miss_d    = st_miss_q;
    st_wb_d      = st_wb_q;
    wr_valid_en  = 1'b0;
    wr_dirty_en  = 1'b0;
    wr_tag_en    = 1'b0;
    wr_data_en   = 1'b0;
    wr_valid     = 1'b0;
    wr_dirty     = 1'b0;
    wr_data      = req_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          req_addr_d  = cpu_req_addr;
          req_write_d = cpu_req_write;
          req_wdata_d = cpu_req_wdata;
          st_req_d    = st_req_q + 32'd1;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          st_hit_d     = st_hit_q + 32'd1;
          wr_data_en   = req_write_q;
          wr_dirty_en  = req_write_q;
          wr_dirty     = 1'b1;
          resp_rdata_d = req_write_q ? req_wdata_q : rd_data;
          resp_hit_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          st_miss_d    = st_miss_q + 32'd1;
          mreq_valid_d = 1'b1;
          // Victim data is captured here so it stays stable under backpressure.
          if (rd_valid && rd_dirty) begin
            mreq_write_d = 1'b1;
            mreq_addr_d  = block_addr(rd_tag, req_index);
            mreq_wdata_d = rd_data;
            state_d      = S_WB_REQ;
          end else begin
            mreq_write_d = 1'b0;
            mreq_addr_d  = block_addr(req_tag, req_index);
            state_d      = S_RF_REQ;
          end
        end
      end
      S_WB_REQ: begin
        if (mem_req_ready) begin
          st_wb_d      = st_wb_q + 32'd1;
          wr_dirty_en  = 1'b1;
          wr_dirty     = 1'b0;
          mreq_write_d = 1'b0;
          mreq_addr_d  = block_addr(req_tag, req_index);
          state_d      = S_RF_REQ;
        end
      end
      S_RF_REQ: begin
        if (mem_req_ready) begin
          mreq_valid_d = 1'b0;
          state_d      = S_RF_WAIT;
        end
      end
      S_RF_WAIT: begin
        if (mem_resp_valid) begin
          wr_valid_en  = 1'b1;
          wr_dirty_en  = 1'b1;
          wr_tag_en    = 1'b1;
          wr_data_en   = 1'b1;
          wr_valid     = 1'b1;
          wr_dirty     = req_write_q;
          wr_data      = fill_data;
          resp_rdata_d = fill_data;
          resp_hit_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      req_write_q  <= 1'b0;
      req_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mreq_valid_q <= 1'b0;
      mreq_write_q <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
      st_req_q     <= '0;
      st_hit_q     <= '0;
      st_miss_q    <= '0;
      st_wb_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_write_q  <= req_write_d;
      req_wdata_q  <= req_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_write_q <= mreq_write_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
      st_req_q     <= st_req_d;
      st_hit_q     <= st_hit_d;
      st_miss_q    <= st_miss_d;
      st_wb_q      <= st_wb_d;
    end
  end

  assign cpu_req_ready   = (state_q == S_IDLE);
  assign cpu_resp_valid  = resp_valid_q;
  assign cpu_resp_hit    = resp_hit_q;
  assign cpu_resp_rdata  = resp_rdata_q;
  assign mem_req_valid   = mreq_valid_q;
  assign mem_req_write   = mreq_write_q;
  assign mem_req_addr    = mreq_addr_q;
  assign mem_req_wdata   = mreq_wdata_q;
  assign stat_requests   = st_req_q;
  assign stat_hits       = st_hit_q;
  assign stat_misses     = st_miss_q;
  assign stat_writebacks = st_wb_q;

endmodule

// File: tb/tb_cache_access_controller.sv
// Directed bench for the cache access controller: hits, misses, writebacks,
// write-allocate, memory backpressure and reset during a refill.
module tb_cache_access_controller;
  import cache_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [15:0] cpu_req_addr;
  line_t       cpu_req_wdata;
  logic        cpu_resp_valid, cpu_resp_hit;
  line_t       cpu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [15:0] mem_req_addr;
  line_t       mem_req_wdata;
  logic        mem_resp_valid;
  line_t       mem_resp_rdata;
  logic [31:0] stat_requests, stat_hits, stat_misses, stat_writebacks;

  int tests = 0;
  int fails = 0;

  localparam line_t D_A5   = {4{32'hA5A5A5A5}};
  localparam line_t D_DEAD = {4{32'hDEADBEEF}};
  localparam line_t D_1234 = 128'h1234;
  localparam line_t D_R1   = {4{32'h11112222}};
  localparam line_t D_R2   = {4{32'h33334444}};
  localparam line_t D_JUNK = {4{32'h0BADF00D}};
  localparam line_t D_R3   = {4{32'h55556666}};

  cache_access_controller dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_req_write   (cpu_req_write),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_wdata   (cpu_req_wdata),
    .cpu_resp_valid  (cpu_resp_valid),
    .cpu_resp_hit    (cpu_resp_hit),
    .cpu_resp_rdata  (cpu_resp_rdata),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_rdata  (mem_resp_rdata),
    .stat_requests   (stat_requests),
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int rq, input int ht, input int ms, input int wb);
    chk({tag, "_requests"},   stat_requests,   rq);
    chk({tag, "_hits"},       stat_hits,       ht);
    chk({tag, "_misses"},     stat_misses,     ms);
    chk({tag, "_writebacks"}, stat_writebacks, wb);
  endtask

  task automatic send_req(input logic wr, input logic [15:0] addr, input line_t wd, input string tag);
    @(posedge clk); #1;
    chk({tag, "_req_ready"}, cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
  endtask

  // Waits (bounded) for a memory request, checks it, holds it off for `stall`
  // cycles checking stability, then accepts it.
  task automatic serve_mem(input logic wr, input logic [15:0] addr, input line_t wd,
                           input int stall, input string tag);
    int n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (mem_req_valid) break;
      n++;
    end
    chk({tag, "_mreq_seen"}, mem_req_valid, 1'b1);
    chk({tag, "_mreq_write"}, mem_req_write, wr);
    chk({tag, "_mreq_addr"}, mem_req_addr, addr);
    if (wr) chk({tag, "_mreq_wdata"}, mem_req_wdata, wd);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_bp_valid"}, mem_req_valid, 1'b1);
      chk({tag, "_bp_addr"}, mem_req_addr, addr);
      chk({tag, "_bp_write"}, mem_req_write, wr);
      if (wr) chk({tag, "_bp_wdata"}, mem_req_wdata, wd);
      chk({tag, "_bp_cpu_ready"}, cpu_req_ready, 1'b0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
  endtask

  task automatic mem_reply(input line_t data);
    repeat (2) @(posedge clk);
    #1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = data;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic do_hit(input logic wr, input logic [15:0] addr, input line_t wd,
                        input line_t exp_data, input string tag);
    send_req(wr, addr, wd, tag);
    @(negedge clk);
    chk({tag, "_lookup_resp"}, cpu_resp_valid, 1'b0);
    chk({tag, "_lookup_mreq"}, mem_req_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_resp_valid"}, cpu_resp_valid, 1'b1);
    chk({tag, "_resp_hit"}, cpu_resp_hit, 1'b1);
    chk({tag, "_resp_data"}, cpu_resp_rdata, exp_data);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, cpu_resp_valid, 1'b0);
  endtask

  task automatic do_miss(input logic wr, input logic [15:0] addr, input line_t wd,
                         input bit wb, input logic [15:0] wb_addr, input line_t wb_data,
                         input int stall, input line_t rf_data, input line_t exp_data,
                         input string tag);
    send_req(wr, addr, wd, tag);
    if (wb) serve_mem(1'b1, wb_addr, wb_data, stall, {tag, "_wb"});
    serve_mem(1'b0, addr & 16'hFFF0, '0, 0, {tag, "_rf"});
    mem_reply(rf_data);
    @(negedge clk);
    chk({tag, "_resp_valid"}, cpu_resp_valid, 1'b1);
    chk({tag, "_resp_hit"}, cpu_resp_hit, 1'b0);
    chk({tag, "_resp_data"}, cpu_resp_rdata, exp_data);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, cpu_resp_valid, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, cpu_req_ready, 1'b1);
    chk({tag, "_resp_valid"}, cpu_resp_valid, 1'b0);
    chk({tag, "_resp_hit"}, cpu_resp_hit, 1'b0);
    chk({tag, "_resp_rdata"}, cpu_resp_rdata, '0);
    chk({tag, "_mreq_valid"}, mem_req_valid, 1'b0);
    chk({tag, "_mreq_write"}, mem_req_write, 1'b0);
    chk({tag, "_mreq_addr"}, mem_req_addr, '0);
    chk({tag, "_mreq_wdata"}, mem_req_wdata, '0);
    chk_stats(tag, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    cpu_req_valid  = 1'b0;
    cpu_req_write  = 1'b0;
    cpu_req_addr   = '0;
    cpu_req_wdata  = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    do_miss(1'b0, 16'h0010, '0, 1'b0, '0, '0, 0, D_A5, D_A5, "rd_miss");
    chk_stats("after_rd_miss", 1, 0, 1, 0);

    do_hit(1'b0, 16'h0010, '0, D_A5, "rd_hit");
    chk_stats("after_rd_hit", 2, 1, 1, 0);

    do_hit(1'b1, 16'h0010, D_DEAD, D_DEAD, "wr_hit");

    do_miss(1'b0, 16'h1010, '0, 1'b1, 16'h0010, D_DEAD, 5, D_R1, D_R1, "wb_rd");
    chk_stats("after_wb", 4, 2, 2, 1);

    do_miss(1'b1, 16'h0020, D_1234, 1'b0, '0, '0, 0, D_JUNK, D_1234, "wr_alloc");

    do_miss(1'b0, 16'h1020, '0, 1'b1, 16'h0020, D_1234, 0, D_R2, D_R2, "alloc_wb");
    chk_stats("after_alloc_wb", 6, 2, 4, 2);

    // Reset while the refill is outstanding, with the response landing during
    // and after reset.
    send_req(1'b0, 16'h0030, '0, "rst_rf");
    serve_mem(1'b0, 16'h0030, '0, 0, "rst_rf");
    @(posedge clk); #1;
    reset_n        = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = D_JUNK;
    #2;
    chk_reset_outputs("rst_in_rfwait");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stray_resp_valid", cpu_resp_valid, 1'b0);
    chk("stray_req_ready", cpu_req_ready, 1'b1);
    chk("stray_mreq_valid", mem_req_valid, 1'b0);
    chk_stats("after_stray", 0, 0, 0, 0);

    do_miss(1'b0, 16'h0030, '0, 1'b0, '0, '0, 0, D_R3, D_R3, "post_rst");
    chk_stats("after_post_rst", 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_access_controller.md
# cache_access_controller

Sequencing controller for the direct-mapped, write-back cache. It accepts whole-block CPU read/write requests over a valid/ready handshake and performs the tag lookup. On a miss it writes back a dirty victim, then refills the line from main memory over a request/response memory port. It also maintains the access statistics counters. It sits between the CPU request path and the main-memory model and owns the tag, valid, dirty and data storage.

## Interface
- ADDR_WIDTH, 16, byte address width
- BLOCK_SIZE, 16, bytes per line (power of 2)
- CACHE_LINES, 16, number of lines (power of 2)
- Derived: OFFSET_WIDTH=clog2(BLOCK_SIZE), INDEX_WIDTH=clog2(CACHE_LINES), TAG_WIDTH=ADDR_WIDTH-OFFSET_WIDTH-INDEX_WIDTH

Ports:
- clk  in  1  single clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  controller can accept
- cpu_req_write  in  1  1=write, 0=read
- cpu_req_addr  in  ADDR_WIDTH  request address (offset bits ignored)
- cpu_req_wdata  in  BLOCK_SIZE*8  write block
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_hit  out  1  1=hit, 0=miss
- cpu_resp_rdata  out  BLOCK_SIZE*8  line contents after the access
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1=writeback, 0=refill read
- mem_req_addr  out  ADDR_WIDTH  block address; offset bits always 0
- mem_req_wdata  out  BLOCK_SIZE*8  victim block
- mem_resp_valid  in  1  refill data valid
- mem_resp_rdata  in  BLOCK_SIZE*8  refill block
- stat_requests, stat_hits, stat_misses, stat_writebacks  out  32 each  counters

## Operation
- States: IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT, RESP.
- IDLE: cpu_req_ready=1 (combinational, IDLE only). valid&ready latches addr, write and wdata; stat_requests+1; goes to LOOKUP.
- LOOKUP: index=addr[OFFSET_WIDTH+:INDEX_WIDTH]. Hit = valid[index] & tag match.
  - Hit: stat_hits+1. A write stores wdata and sets dirty. Goes to RESP with hit=1.
  - Miss: stat_misses+1. Goes to WB_REQ if valid&dirty, otherwise RF_REQ.
- WB_REQ: mem_req_valid=1, write=1, addr={old_tag,index,0}, wdata=stored line. On mem_req_ready: stat_writebacks+1, clear dirty, go to RF_REQ.
- RF_REQ: mem_req_valid=1, write=0, addr={tag,index,0}. On mem_req_ready go to RF_WAIT.
- RF_WAIT: on mem_resp_valid, install valid=1 and the new tag. Data = write ? latched wdata : mem_resp_rdata; dirty = write. Goes to RESP with hit=0.
- RESP: cpu_resp_valid=1 for exactly one cycle; rdata = resulting line. Returns to IDLE. There is no response backpressure.
- mem_req_* fields are held stable while mem_req_valid=1 and ready=0.
- mem_resp_valid outside RF_WAIT is ignored.
- Counters wrap modulo 2^32.

## Timing
- Hit latency: accept edge E0, LOOKUP cycle, state update at E1, cpu_resp_valid high in the cycle after E1.
- Miss latency: 2 cycles plus memory handshake and response wait. The writeback adds at least one cycle.
- Reset values: state=IDLE, cpu_req_ready=1, cpu_resp_valid=0, cpu_resp_hit=0, cpu_resp_rdata=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0, all counters 0, all valid/dirty bits 0. The data/tag arrays are not reset.
- Reset mid-operation aborts at once. A memory response arriving after reset is ignored. The line being refilled remains invalid.

## Structure
- Package cache_ctrl_pkg:
  - state enum
  - field-width derivation constants/functions
  - address split helpers (tag/index extraction, block-address build)
- Sub-module cache_line_store:
  - per-line tag/valid/dirty/data arrays
  - combinational read by index
  - single write port with separate valid/dirty/tag/data enables
  - asynchronous clear of valid and dirty on reset_n

## Test plan
(Defaults: address 0x0010 has index 1, tag 0x00.)
- Read miss: after reset, read 0x0010; memory returns 128'hA5A5… after 3 cycles -> mem read at 0x0010, resp hit=0 with that data; requests=1, misses=1.
- Read hit: read 0x0010 again -> no mem_req_valid; resp 2 cycles after accept with hit=1; hits=1.
- Writeback: write hit 0x0010 with 128'hDEADBEEF… -> hit=1. Then read 0x1010 -> mem write to 0x0010 with DEADBEEF…, then mem read at 0x1010; writebacks=1, misses=2.
- Write-allocate: write miss 0x0020 with 128'h1234 -> refill read at 0x0020, line holds 128'h1234, dirty. Then read 0x1020 -> writeback of 128'h1234 to 0x0020.
- Backpressure: hold mem_req_ready=0 for 5 cycles -> mem_req_* stable, cpu_req_ready=0 throughout.
- Reset in RF_WAIT -> outputs at reset values. A stray mem_resp_valid in IDLE is ignored. A subsequent read to the same address misses.
